// File: rtl/video_pkg.sv
// Shared constants and elaboration helpers for the VGA output path.
// Default geometry, tile size and width-check functions used by the coordinate tracker.
package video_pkg;

    localparam int H_ACTIVE_DEF        = 640;
    localparam int V_ACTIVE_DEF        = 480;
    localparam int X_WIDTH_DEF         = 10;
    localparam int Y_WIDTH_DEF         = 10;
    localparam int TILE_SHIFT_DEF      = 4;
    localparam int FRAME_CNT_WIDTH_DEF = 8;

    // True when a counter of 'width' bits can hold the indices 0..count-1.
    function automatic bit fits_width(input int count, input int width);
        return $clog2(count) <= width;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; clear beats increment.
// Used for the x and y coordinate axes of the screen tracker.
module wrap_counter #(
    parameter int MAX   = 639,
    parameter int WIDTH = 10
) (
    input  logic             pixel_clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             at_max
);

    logic [WIDTH-1:0] value_reg;
    logic [WIDTH-1:0] value_next;

    assign at_max = (value_reg == WIDTH'(MAX));
    assign value  = value_reg;

    always_comb begin
        value_next = value_reg;
        if (clr) begin
            value_next = '0;
        end else if (inc) begin
            value_next = at_max ? '0 : value_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

endmodule

// File: rtl/screen_coord_tracker.sv
// Active-area coordinate tracker: screen/tile coordinates, line and frame strobes,
// frame counter, and a sticky flag for frame_sync arriving away from the origin.
module screen_coord_tracker
    import video_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int X_WIDTH         = X_WIDTH_DEF,
    parameter int Y_WIDTH         = Y_WIDTH_DEF,
    parameter int TILE_SHIFT      = TILE_SHIFT_DEF,
    parameter int FRAME_CNT_WIDTH = FRAME_CNT_WIDTH_DEF
) (
    input  logic                          pixel_clk,
    input  logic                          reset,
    input  logic                          video_enable,
    input  logic                          frame_sync,
    output logic [X_WIDTH-1:0]            screen_pixel_x,
    output logic [Y_WIDTH-1:0]            screen_pixel_y,
    output logic [X_WIDTH-TILE_SHIFT-1:0] tile_x,
    output logic [Y_WIDTH-TILE_SHIFT-1:0] tile_y,
    output logic [TILE_SHIFT-1:0]         tile_px_x,
    output logic [TILE_SHIFT-1:0]         tile_px_y,
    output logic                          line_start,
    output logic                          line_end,
    output logic                          frame_start,
    output logic                          frame_end,
    output logic [FRAME_CNT_WIDTH-1:0]    frame_count,
    output logic                          sync_error
);

    if (!fits_width(H_ACTIVE, X_WIDTH)) begin : g_bad_x_width
        $error("screen_coord_tracker: H_ACTIVE does not fit in X_WIDTH bits");
    end
    if (!fits_width(V_ACTIVE, Y_WIDTH)) begin : g_bad_y_width
        $error("screen_coord_tracker: V_ACTIVE does not fit in Y_WIDTH bits");
    end
    if (TILE_SHIFT >= min_int(X_WIDTH, Y_WIDTH)) begin : g_bad_tile_shift
        $error("screen_coord_tracker: TILE_SHIFT must be below both coordinate widths");
    end

    logic [X_WIDTH-1:0]         x_value;
    logic [Y_WIDTH-1:0]         y_value;
    logic                       x_at_max;
    logic                       y_at_max;
    logic                       at_origin;
    logic [FRAME_CNT_WIDTH-1:0] frame_count_reg;
    logic [FRAME_CNT_WIDTH-1:0] frame_count_next;
    logic                       sync_error_reg;
    logic                       sync_error_next;

    // frame_sync drives clr on both axes, so it overrides any enabled increment.
    wrap_counter #(
        .MAX   (H_ACTIVE - 1),
        .WIDTH (X_WIDTH)
    ) u_x_counter (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .inc       (video_enable),
        .clr       (frame_sync),
        .value     (x_value),
        .at_max    (x_at_max)
    );

    wrap_counter #(
        .MAX   (V_ACTIVE - 1),
        .WIDTH (Y_WIDTH)
    ) u_y_counter (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .inc       (x_at_max & video_enable),
        .clr       (frame_sync),
        .value     (y_value),
        .at_max    (y_at_max)
    );

    assign at_origin = (x_value == '0) && (y_value == '0);

    assign screen_pixel_x = x_value;
    assign screen_pixel_y = y_value;
    assign tile_x         = x_value[X_WIDTH-1:TILE_SHIFT];
    assign tile_y         = y_value[Y_WIDTH-1:TILE_SHIFT];
    assign tile_px_x      = x_value[TILE_SHIFT-1:0];
    assign tile_px_y      = y_value[TILE_SHIFT-1:0];

    assign line_start  = video_enable & (x_value == '0);
    assign line_end    = video_enable & x_at_max;
    assign frame_start = line_start & (y_value == '0);
    assign frame_end   = line_end & y_at_max;

    // A frame completed in the same cycle as frame_sync still counts.
    always_comb begin
        frame_count_next = frame_count_reg + FRAME_CNT_WIDTH'(frame_end);
        sync_error_next  = sync_error_reg | (frame_sync & ~at_origin);
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            frame_count_reg <= '0;
            sync_error_reg  <= 1'b0;
        end else begin
            frame_count_reg <= frame_count_next;
            sync_error_reg  <= sync_error_next;
        end
    end

    assign frame_count = frame_count_reg;
    assign sync_error  = sync_error_reg;

endmodule

// File: tb/tb_screen_coord_tracker.sv
// Randomised bench for screen_coord_tracker: three geometries checked against a
// linear-pixel-index reference model, plus directed boundary scenarios.
module tb_screen_coord_tracker;

    typedef struct packed {
        integer x;
        integer y;
        integer tx;
        integer ty;
        integer px;
        integer py;
        integer ls;
        integer le;
        integer fs;
        integer fe;
        integer fc;
        integer se;
    } obs_t;

    logic       clk = 1'b0;
    logic [2:0] rst = '0;
    logic [2:0] en = '0;
    logic [2:0] sync = '0;

    int checks = 0;
    int errors = 0;

    // Reference model: pixel index within the frame, completed frames, sticky error.
    int mp[3];
    int mfc[3];
    bit mse[3];

    always #5 clk = ~clk;

    logic [9:0] x0, y0;
    logic [5:0] tx0, ty0;
    logic [3:0] px0, py0;
    logic [7:0] fc0;
    logic       ls0, le0, fs0, fe0, se0;

    logic [2:0] x1;
    logic [1:0] y1;
    logic [1:0] tx1;
    logic [0:0] ty1, px1, py1;
    logic [1:0] fc1;
    logic       ls1, le1, fs1, fe1, se1;

    logic [5:0] x2, y2;
    logic [1:0] tx2, ty2;
    logic [3:0] px2, py2;
    logic [7:0] fc2;
    logic       ls2, le2, fs2, fe2, se2;

    screen_coord_tracker u_dut_default (
        .pixel_clk (clk), .reset (rst[0]), .video_enable (en[0]), .frame_sync (sync[0]),
        .screen_pixel_x (x0), .screen_pixel_y (y0), .tile_x (tx0), .tile_y (ty0),
        .tile_px_x (px0), .tile_px_y (py0), .line_start (ls0), .line_end (le0),
        .frame_start (fs0), .frame_end (fe0), .frame_count (fc0), .sync_error (se0)
    );

    screen_coord_tracker #(
        .H_ACTIVE (8), .V_ACTIVE (4), .X_WIDTH (3), .Y_WIDTH (2),
        .TILE_SHIFT (1), .FRAME_CNT_WIDTH (2)
    ) u_dut_small (
        .pixel_clk (clk), .reset (rst[1]), .video_enable (en[1]), .frame_sync (sync[1]),
        .screen_pixel_x (x1), .screen_pixel_y (y1), .tile_x (tx1), .tile_y (ty1),
        .tile_px_x (px1), .tile_px_y (py1), .line_start (ls1), .line_end (le1),
        .frame_start (fs1), .frame_end (fe1), .frame_count (fc1), .sync_error (se1)
    );

    screen_coord_tracker #(
        .H_ACTIVE (64), .V_ACTIVE (48), .X_WIDTH (6), .Y_WIDTH (6),
        .TILE_SHIFT (4), .FRAME_CNT_WIDTH (8)
    ) u_dut_medium (
        .pixel_clk (clk), .reset (rst[2]), .video_enable (en[2]), .frame_sync (sync[2]),
        .screen_pixel_x (x2), .screen_pixel_y (y2), .tile_x (tx2), .tile_y (ty2),
        .tile_px_x (px2), .tile_px_y (py2), .line_start (ls2), .line_end (le2),
        .frame_start (fs2), .frame_end (fe2), .frame_count (fc2), .sync_error (se2)
    );

    function automatic int h_of(input int d);
        return (d == 0) ? 640 : (d == 1) ? 8 : 64;
    endfunction
    function automatic int v_of(input int d);
        return (d == 0) ? 480 : (d == 1) ? 4 : 48;
    endfunction
    function automatic int ts_of(input int d);
        return (d == 1) ? 1 : 4;
    endfunction
    function automatic int fcm_of(input int d);
        return (d == 1) ? 4 : 256;
    endfunction

    function automatic obs_t exp_obs(input int d);
        obs_t o;
        int   h;
        int   t;
        h    = h_of(d);
        t    = 1 << ts_of(d);
        o.x  = mp[d] % h;
        o.y  = mp[d] / h;
        o.tx = o.x / t;
        o.ty = o.y / t;
        o.px = o.x % t;
        o.py = o.y % t;
        o.ls = (en[d] && o.x == 0) ? 1 : 0;
        o.le = (en[d] && o.x == h - 1) ? 1 : 0;
        o.fs = (o.ls == 1 && o.y == 0) ? 1 : 0;
        o.fe = (o.le == 1 && o.y == v_of(d) - 1) ? 1 : 0;
        o.fc = mfc[d] % fcm_of(d);
        o.se = mse[d] ? 1 : 0;
        return o;
    endfunction

    function automatic obs_t act_obs(input int d);
        obs_t o;
        case (d)
            0: o = '{x0, y0, tx0, ty0, px0, py0, ls0, le0, fs0, fe0, fc0, se0};
            1: o = '{x1, y1, tx1, ty1, px1, py1, ls1, le1, fs1, fe1, fc1, se1};
            default: o = '{x2, y2, tx2, ty2, px2, py2, ls2, le2, fs2, fe2, fc2, se2};
        endcase
        return o;
    endfunction

    function automatic string obs_str(input obs_t o);
        return $sformatf("x=%0d y=%0d tx=%0d ty=%0d px=%0d py=%0d ls=%0d le=%0d fs=%0d fe=%0d fc=%0d se=%0d",
                         o.x, o.y, o.tx, o.ty, o.px, o.py, o.ls, o.le, o.fs, o.fe, o.fc, o.se);
    endfunction

    // Advance one clock; the model consumes the inputs that were present before the edge.
    task automatic tick();
        logic [2:0] r_s, e_s, s_s;
        int         last;
        r_s = rst;
        e_s = en;
        s_s = sync;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            last = h_of(d) * v_of(d) - 1;
            if (r_s[d]) begin
                mp[d]  = 0;
                mfc[d] = 0;
                mse[d] = 1'b0;
            end else begin
                if (e_s[d] && mp[d] == last) mfc[d]++;
                if (s_s[d]) begin
                    if (mp[d] != 0) mse[d] = 1'b1;
                    mp[d] = 0;
                end else if (e_s[d]) begin
                    mp[d] = (mp[d] == last) ? 0 : mp[d] + 1;
                end
            end
        end
        #1;
    endtask

    task automatic apply(input int d, input logic e, input logic s);
        en[d]   = e;
        sync[d] = s;
        #1;
    endtask

    task automatic do_reset(input int d);
        rst[d]  = 1'b1;
        en[d]   = 1'b0;
        sync[d] = 1'b0;
        tick();
        rst[d] = 1'b0;
    endtask

    task automatic advance_to(input int d, input int target, input int budget, output bit ok);
        int n = 0;
        while (mp[d] != target && n < budget) begin
            apply(d, $urandom_range(0, 6) != 0, 1'b0);
            tick();
            n++;
        end
        ok = (mp[d] == target);
        apply(d, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        obs_t ex, ac;
        for (int d = 0; d < 3; d++) begin
            rst[d]  = 1'b1;
            en[d]   = 1'($urandom_range(0, 1));
            sync[d] = 1'($urandom_range(0, 1));
        end
        tick();
        rst = '0;
        for (int d = 0; d < 3; d++) begin
            apply(d, 1'b0, 1'b0);
            ex = exp_obs(d);
            ac = act_obs(d);
            checks++;
            if (ac !== ex) begin
                errors++;
                $display("FAIL reset_state dut%0d got %s want %s", d, obs_str(ac), obs_str(ex));
            end
        end
        apply(0, 1'b1, 1'b0);
        checks++;
        if ({ls0, fs0, le0, fe0, x0, y0, fc0, se0} !== {4'b1100, 10'd0, 10'd0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_strobes got ls=%0d fs=%0d le=%0d fe=%0d x=%0d y=%0d want ls=1 fs=1 le=0 fe=0 x=0 y=0",
                     ls0, fs0, le0, fe0, x0, y0);
        end
        apply(0, 1'b0, 1'b0);
        $display("test_reset done");
    endtask

    task automatic test_sustained();
        obs_t ex, ac;
        do_reset(0);
        for (int i = 0; i < 640; i++) begin
            apply(0, 1'b1, 1'b0);
            ex = exp_obs(0);
            ac = act_obs(0);
            checks++;
            if (ac !== ex || x0 !== 10'(i) || y0 !== 10'd0 || ls0 !== (i == 0) || le0 !== (i == 639)) begin
                errors++;
                $display("FAIL sustained cycle %0d got %s want %s", i, obs_str(ac), obs_str(ex));
            end
            tick();
        end
        apply(0, 1'b0, 1'b0);
        checks++;
        if (x0 !== 10'd0 || y0 !== 10'd1) begin
            errors++;
            $display("FAIL sustained_wrap got x=%0d y=%0d want x=0 y=1", x0, y0);
        end
        $display("test_sustained done");
    endtask

    task automatic test_tile_decode();
        bit ok;
        do_reset(0);
        advance_to(0, 18 * 640 + 37, 30000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tile_reach got pixel_index=%0d want %0d", mp[0], 18 * 640 + 37);
        end
        checks++;
        if ({x0, y0, tx0, px0, ty0, py0} !== {10'd37, 10'd18, 6'd2, 4'd5, 6'd1, 4'd2}) begin
            errors++;
            $display("FAIL tile_decode got x=%0d y=%0d tx=%0d px=%0d ty=%0d py=%0d want 37 18 2 5 1 2",
                     x0, y0, tx0, px0, ty0, py0);
        end
        $display("test_tile_decode done");
    endtask

    task automatic test_misaligned_sync();
        bit ok;
        do_reset(0);
        advance_to(0, 5 * 640 + 100, 10000, ok);
        checks++;
        if (!ok || x0 !== 10'd100 || y0 !== 10'd5 || se0 !== 1'b0) begin
            errors++;
            $display("FAIL misalign_reach got x=%0d y=%0d se=%0d want x=100 y=5 se=0", x0, y0, se0);
        end
        apply(0, 1'($urandom_range(0, 1)), 1'b1);
        tick();
        apply(0, 1'b0, 1'b0);
        checks++;
        if (x0 !== 10'd0 || y0 !== 10'd0 || se0 !== 1'b1 || fc0 !== 8'd0) begin
            errors++;
            $display("FAIL misalign_sync got x=%0d y=%0d se=%0d fc=%0d want 0 0 1 0", x0, y0, se0, fc0);
        end
        for (int i = 0; i < 40; i++) begin
            apply(0, 1'($urandom_range(0, 1)), 1'b0);
            tick();
            checks++;
            if (se0 !== 1'b1) begin
                errors++;
                $display("FAIL sticky_error cycle %0d got se=%0d want 1", i, se0);
            end
        end
        do_reset(0);
        apply(0, 1'b0, 1'b0);
        checks++;
        if (se0 !== 1'b0) begin
            errors++;
            $display("FAIL error_cleared got se=%0d want 0", se0);
        end
        $display("test_misaligned_sync done");
    endtask

    task automatic test_sync_at_origin();
        do_reset(0);
        apply(0, 1'b1, 1'b1);
        checks++;
        if (fs0 !== 1'b1) begin
            errors++;
            $display("FAIL origin_strobe got fs=%0d want 1", fs0);
        end
        tick();
        apply(0, 1'b0, 1'b0);
        checks++;
        if (x0 !== 10'd0 || y0 !== 10'd0 || se0 !== 1'b0 || fc0 !== 8'd0) begin
            errors++;
            $display("FAIL origin_sync got x=%0d y=%0d se=%0d fc=%0d want 0 0 0 0", x0, y0, se0, fc0);
        end
        $display("test_sync_at_origin done");
    endtask

    task automatic test_full_frame();
        obs_t ex, ac;
        int   fe_seen = 0;
        do_reset(2);
        for (int line = 0; line < 48; line++) begin
            for (int i = 0; i < 64 + 160; i++) begin
                apply(2, i < 64, 1'b0);
                ex = exp_obs(2);
                ac = act_obs(2);
                if (fe2 === 1'b1) fe_seen++;
                checks++;
                if (ac !== ex) begin
                    errors++;
                    $display("FAIL full_frame line %0d slot %0d got %s want %s", line, i, obs_str(ac), obs_str(ex));
                end
                tick();
            end
        end
        apply(2, 1'b0, 1'b0);
        checks++;
        if (fe_seen != 1 || x2 !== 6'd0 || y2 !== 6'd0 || fc2 !== 8'd1 || se2 !== 1'b0) begin
            errors++;
            $display("FAIL full_frame_end got fe_count=%0d x=%0d y=%0d fc=%0d se=%0d want 1 0 0 1 0",
                     fe_seen, x2, y2, fc2, se2);
        end
        $display("test_full_frame done");
    endtask

    task automatic test_sync_at_end();
        bit   ok;
        obs_t ex, ac;
        do_reset(1);
        advance_to(1, 31, 500, ok);
        apply(1, 1'b1, 1'b1);
        checks++;
        if (!ok || fe1 !== 1'b1) begin
            errors++;
            $display("FAIL end_strobe got fe=%0d x=%0d y=%0d want fe=1 x=7 y=3", fe1, x1, y1);
        end
        tick();
        apply(1, 1'b0, 1'b0);
        ex = exp_obs(1);
        ac = act_obs(1);
        checks++;
        if (ac !== ex || x1 !== 3'd0 || y1 !== 2'd0 || fc1 !== 2'd1) begin
            errors++;
            $display("FAIL end_sync got %s want %s", obs_str(ac), obs_str(ex));
        end
        $display("test_sync_at_end done");
    endtask

    task automatic test_frame_wrap();
        obs_t ex, ac;
        int   enabled = 0;
        int   n = 0;
        do_reset(1);
        while (enabled < 5 * 32 && n < 2000) begin
            apply(1, $urandom_range(0, 2) != 0, 1'b0);
            if (en[1]) enabled++;
            ex = exp_obs(1);
            ac = act_obs(1);
            checks++;
            if (ac !== ex) begin
                errors++;
                $display("FAIL wrap cycle %0d got %s want %s", n, obs_str(ac), obs_str(ex));
            end
            tick();
            n++;
        end
        apply(1, 1'b0, 1'b0);
        checks++;
        if (enabled != 160 || fc1 !== 2'd1 || x1 !== 3'd0 || y1 !== 2'd0) begin
            errors++;
            $display("FAIL wrap_count got fc=%0d x=%0d y=%0d enabled=%0d want 1 0 0 160", fc1, x1, y1, enabled);
        end
        $display("test_frame_wrap done");
    endtask

    task automatic test_midframe_reset();
        bit ok;
        do_reset(1);
        advance_to(1, 2 * 8 + 3, 500, ok);
        checks++;
        if (!ok || x1 !== 3'd3 || y1 !== 2'd2) begin
            errors++;
            $display("FAIL midreset_reach got x=%0d y=%0d want 3 2", x1, y1);
        end
        rst[1] = 1'b1;
        apply(1, 1'b1, 1'($urandom_range(0, 1)));
        tick();
        rst[1] = 1'b0;
        apply(1, 1'b0, 1'b0);
        checks++;
        if ({x1, y1, fc1, se1, ls1, le1, fs1, fe1} !== '0) begin
            errors++;
            $display("FAIL midreset got x=%0d y=%0d fc=%0d se=%0d want all 0", x1, y1, fc1, se1);
        end
        $display("test_midframe_reset done");
    endtask

    task automatic test_random();
        obs_t ex, ac;
        for (int n = 0; n < 4000; n++) begin
            for (int d = 0; d < 3; d++) begin
                rst[d]  = ($urandom_range(0, 199) == 0);
                en[d]   = ($urandom_range(0, 3) != 0);
                sync[d] = ($urandom_range(0, 99) == 0);
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                ex = exp_obs(d);
                ac = act_obs(d);
                checks++;
                if (ac !== ex) begin
                    errors++;
                    $display("FAIL random cycle %0d dut%0d got %s want %s", n, d, obs_str(ac), obs_str(ex));
                end
            end
            tick();
        end
        rst  = '0;
        en   = '0;
        sync = '0;
        $display("test_random done");
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            mp[d]  = 0;
            mfc[d] = 0;
            mse[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_sustained();
        test_tile_decode();
        test_misaligned_sync();
        test_sync_at_origin();
        test_full_frame();
        test_sync_at_end();
        test_frame_wrap();
        test_midframe_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
